// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter: widths, reservation-station
// tags and requester indices.
package cdb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int ROB_W  = 2;

  // Tag 0 on the bus means "nothing broadcast this cycle".
  localparam logic [TAG_W-1:0] NOTAG  = 4'd0;
  localparam logic [TAG_W-1:0] ADD_1  = 4'd1;
  localparam logic [TAG_W-1:0] ADD_2  = 4'd2;
  localparam logic [TAG_W-1:0] ADD_3  = 4'd3;
  localparam logic [TAG_W-1:0] MULT_1 = 4'd4;
  localparam logic [TAG_W-1:0] MULT_2 = 4'd5;
  localparam logic [TAG_W-1:0] LD_1   = 4'd6;
  localparam logic [TAG_W-1:0] LD_2   = 4'd7;
  localparam logic [TAG_W-1:0] LD_3   = 4'd8;
  localparam logic [TAG_W-1:0] ST_1   = 4'd9;
  localparam logic [TAG_W-1:0] ST_2   = 4'd10;

  typedef enum logic [1:0] {
    REQ_ADD  = 2'd0,
    REQ_MULT = 2'd1,
    REQ_LD   = 2'd2,
    REQ_ST   = 2'd3
  } req_idx_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: one-hot grant to the first eligible
// index found scanning ptr, ptr+1, ... modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [2*NREQ-1:0] dbl_elig;
  logic [2*NREQ-1:0] dbl_gnt;
  logic [NREQ-1:0]   rot_elig;
  logic [NREQ-1:0]   rot_gnt;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  // Relies on ptr < NREQ, which the owner of the pointer guarantees.
  always_comb begin
    dbl_elig = {elig, elig} >> ptr;
    rot_elig = dbl_elig[NREQ-1:0];
    rot_gnt  = rot_elig & (~rot_elig + NREQ'(1));
    dbl_gnt  = {rot_gnt, rot_gnt} << ptr;
    grant    = dbl_gnt[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter onto the common data bus: picks one ready reservation
// station per cycle and registers its tag/data/ROB slot as the next broadcast.
module cdb_arbiter #(
  parameter int NREQ   = cdb_pkg::N_REQ,
  parameter int DATA_W = cdb_pkg::DATA_W,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int ROB_W  = cdb_pkg::ROB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*ROB_W-1:0]    req_rob,
  input  logic                     cdb_stall,
  output logic [NREQ-1:0]          grant,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_id,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic                     bad_req
);

  import cdb_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   tag_zero;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   pick;

  logic [PTR_W-1:0]  rr_ptr_d,    rr_ptr_q;
  logic              cdb_valid_d, cdb_valid_q;
  logic [TAG_W-1:0]  cdb_id_d,    cdb_id_q;
  logic [DATA_W-1:0] cdb_data_d,  cdb_data_q;
  logic [ROB_W-1:0]  cdb_rob_d,   cdb_rob_q;
  logic              bad_req_d,   bad_req_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign tag_zero[i] = (req_tag[i*TAG_W +: TAG_W] == TAG_W'(NOTAG));
  end

  // A request carrying the idle tag can never be broadcast.
  assign elig = req & ~tag_zero;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .grant (pick)
  );

  // Requesters treat grant as an ack, so it must be silent under stall/reset.
  assign grant = (rst || cdb_stall) ? '0 : pick;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_id_d    = '0;
    cdb_data_d  = '0;
    cdb_rob_d   = '0;
    bad_req_d   = |(req & tag_zero);
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        cdb_valid_d = 1'b1;
        cdb_id_d    = req_tag[i*TAG_W +: TAG_W];
        cdb_data_d  = req_data[i*DATA_W +: DATA_W];
        cdb_rob_d   = req_rob[i*ROB_W +: ROB_W];
        rr_ptr_d    = (i == NREQ-1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_data_q  <= '0;
      cdb_rob_q   <= '0;
      bad_req_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_id_q    <= cdb_id_d;
      cdb_data_q  <= cdb_data_d;
      cdb_rob_q   <= cdb_rob_d;
      bad_req_q   <= bad_req_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_id    = cdb_id_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_rob   = cdb_rob_q;
  assign bad_req   = bad_req_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a
// queue, a negedge monitor pops and compares whenever the bus is valid.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int RW = 2;

  typedef struct {
    logic [TW-1:0] id;
    logic [DW-1:0] data;
    logic [RW-1:0] rob;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*TW-1:0]  req_tag;
  logic [NR*DW-1:0]  req_data;
  logic [NR*RW-1:0]  req_rob;
  logic              cdb_stall;
  logic [NR-1:0]     grant;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_id;
  logic [DW-1:0]     cdb_data;
  logic [RW-1:0]     cdb_rob;
  logic              bad_req;

  logic [TW-1:0] tg [NR];
  logic [DW-1:0] dt [NR];
  logic [RW-1:0] rb [NR];

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_rob   (req_rob),
    .cdb_stall (cdb_stall),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_id    (cdb_id),
    .cdb_data  (cdb_data),
    .cdb_rob   (cdb_rob),
    .bad_req   (bad_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [NR-1:0] r);
    req = r;
    for (int i = 0; i < NR; i++) begin
      req_tag[i*TW +: TW]  = tg[i];
      req_data[i*DW +: DW] = dt[i];
      req_rob[i*RW +: RW]  = rb[i];
    end
  endtask

  task automatic push_for(input logic [NR-1:0] g);
    exp_t e;
    for (int i = 0; i < NR; i++)
      if (g[i]) begin
        e.id = tg[i]; e.data = dt[i]; e.rob = rb[i];
        q.push_back(e);
      end
  endtask

  // One arbitration cycle: check grant/bad_req mid-cycle, then advance.
  task automatic step(input logic [NR-1:0] eg, input logic eb);
    @(negedge clk);
    chk("grant", 64'(grant), 64'(eg));
    chk("bad_req", 64'(bad_req), 64'(eb));
    push_for(eg);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cdb_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got id=%0h data=%0h with no broadcast expected (t=%0t)",
                 cdb_id, cdb_data, $time);
      end else begin
        mon_e = q.pop_front();
        if (cdb_id !== mon_e.id || cdb_data !== mon_e.data || cdb_rob !== mon_e.rob) begin
          errors++;
          $display("FAIL bus_fields: got id=%0h data=%0h rob=%0h expected id=%0h data=%0h rob=%0h (t=%0t)",
                   cdb_id, cdb_data, cdb_rob, mon_e.id, mon_e.data, mon_e.rob, $time);
        end
      end
    end else begin
      checks++;
      if (cdb_id !== '0 || cdb_data !== '0 || cdb_rob !== '0) begin
        errors++;
        $display("FAIL bus_idle: got id=%0h data=%0h rob=%0h expected all 0 (t=%0t)",
                 cdb_id, cdb_data, cdb_rob, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin tg[i] = '0; dt[i] = '0; rb[i] = '0; end
    rst = 1'b1; cdb_stall = 1'b0;
    drive(4'b0000);

    // Reset state
    #2;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_id",    64'(cdb_id),    64'd0);
    chk("rst_data",  cdb_data,       64'd0);
    chk("rst_rob",   64'(cdb_rob),   64'd0);
    chk("rst_bad",   64'(bad_req),   64'd0);
    chk("rst_grant", 64'(grant),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step(4'b0000, 1'b0);

    // Single request, then drop
    tg[0] = 4'd1; dt[0] = 64'h55; rb[0] = 2'd2;
    drive(4'b0001); step(4'b0001, 1'b0);
    drive(4'b0000); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

    // Pointer at 1: lone requester 3 wins and pointer wraps to 0
    tg[3] = 4'd9; dt[3] = 64'hDEAD_0003; rb[3] = 2'd1;
    drive(4'b1000); step(4'b1000, 1'b0);
    drive(4'b0000); step(4'b0000, 1'b0);

    // Round-robin with all four held
    tg[0] = 4'd1; tg[1] = 4'd4; tg[2] = 4'd6; tg[3] = 4'd9;
    dt[0] = 64'hA0A0_0000_0000_0010; dt[1] = 64'hB1B1_0000_0000_0011;
    dt[2] = 64'hC2C2_0000_0000_0012; dt[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    rb[0] = 2'd0; rb[1] = 2'd1; rb[2] = 2'd2; rb[3] = 2'd3;
    drive(4'b1111);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0100, 1'b0);
    step(4'b1000, 1'b0); step(4'b0001, 1'b0);
    drive(4'b0000); step(4'b0000, 1'b0);

    // Stall three cycles with two pending, pointer at 1
    tg[1] = 4'd5; dt[1] = 64'h1234; rb[1] = 2'd3;
    tg[2] = 4'd7; dt[2] = 64'h5678; rb[2] = 2'd0;
    cdb_stall = 1'b1; drive(4'b0110);
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
    cdb_stall = 1'b0;
    step(4'b0010, 1'b0);
    drive(4'b0100); step(4'b0100, 1'b0);
    drive(4'b0000); step(4'b0000, 1'b0);

    // Tag-zero request: never granted, flagged one cycle later
    tg[3] = 4'd0;
    drive(4'b1000); step(4'b0000, 1'b0);
    tg[0] = 4'd2; dt[0] = 64'h77; rb[0] = 2'd3;
    drive(4'b1001); step(4'b0001, 1'b1);
    drive(4'b0000); step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Async reset while a broadcast of tag 5 is on the bus (pointer then 2)
    tg[1] = 4'd5; dt[1] = 64'hCAFE; rb[1] = 2'd1;
    tg[3] = 4'd10; dt[3] = 64'hBEEF; rb[3] = 2'd2;
    drive(4'b0010); step(4'b0010, 1'b0);
    drive(4'b1010);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_id",    64'(cdb_id),    64'd0);
    chk("midrst_data",  cdb_data,       64'd0);
    chk("midrst_grant", 64'(grant),     64'd0);
    q.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("postrst_grant", 64'(grant), 64'(4'b0010));
    push_for(4'b0010);
    @(posedge clk); #1;
    drive(4'b1000); step(4'b1000, 1'b0);
    drive(4'b0000); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

    @(negedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits between the functional-unit reservation stations (adder, multiplier, load, store) and the common data bus (CDB).
- Each cycle it selects at most one ready requester with round-robin fairness, grants it, and drives the registered CDB broadcast (tag, data, ROB slot) the following cycle.
- The reservation stations and the ROB snoop this broadcast for operand capture and completion.
- Tag 0 (notag) on the bus means idle.

Parameters:
NREQ, 4, number of requesters (0=add, 1=mult, 2=ld, 3=st)
DATA_W, 64, CDB data width
TAG_W, 4, reservation-station tag width
ROB_W, 2, ROB slot index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester write request (level; held until granted)
req_tag  in  NREQ*TAG_W  packed tags; requester i in [i*TAG_W +: TAG_W]
req_data  in  NREQ*DATA_W  packed result data
req_rob  in  NREQ*ROB_W  packed destination ROB slot
cdb_stall  in  1  ROB cannot accept a completion this cycle
grant  out  NREQ  one-hot combinational grant, same cycle as selection
cdb_valid  out  1  registered broadcast valid
cdb_id  out  TAG_W  registered broadcast tag (0 when idle)
cdb_data  out  DATA_W  registered broadcast data (0 when idle)
cdb_rob  out  ROB_W  registered broadcast ROB slot
bad_req  out  1  registered pulse: some req bit asserted with tag 0 last cycle

Behaviour:
- Reset (async, rst=1):
  - cdb_valid=0, cdb_id=0, cdb_data=0, cdb_rob=0, bad_req=0.
  - Round-robin pointer rr_ptr=0.
  - grant=0 while rst is high.
- Eligibility: requester i is eligible iff req[i]=1 and its tag is nonzero. A req with tag 0 is never granted.
- Selection (combinational):
  - If cdb_stall=0 and any requester is eligible, grant the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Otherwise grant=0.
  - grant has at most one bit set.
- Grant handshake:
  - The requester sees grant[i] high and frees its entry at the same posedge (it treats grant as an ack).
  - It must keep req, tag, data and rob stable until granted.
  - Deasserting req before grant is legal (request withdrawn); no broadcast results.
- Pipeline, with a grant to i in cycle N, at posedge end of cycle N:
  - cdb_valid<=1.
  - cdb_id/cdb_data/cdb_rob<= requester i's fields.
  - rr_ptr<=(i+1) mod NREQ.
  - Visible during cycle N+1. Latency from grant to bus is 1 cycle. Throughput is 1 broadcast per cycle.
- No grant in cycle N: at posedge, cdb_valid<=0, cdb_id<=0, cdb_data<=0, cdb_rob<=0. rr_ptr is unchanged.
- cdb_stall=1:
  - No grant. Next-cycle bus is idle and rr_ptr holds.
  - Pending requests stay pending. Stall does not retract a broadcast already registered.
- Wrap-around: pointer at NREQ-1 with grant to NREQ-1 gives rr_ptr=0.
- Fairness: every requester holding req continuously is granted within NREQ consecutive non-stalled cycles.
- Single requester: it is granted every non-stalled cycle it requests (back-to-back broadcasts allowed).
- bad_req: registered OR over i of (req[i] & tag_i==0); a one-cycle pulse per offending cycle. The arbiter ignores it otherwise.
- Reset asserted mid-broadcast: outputs clear immediately (async). The in-flight result is lost; the reset is system-wide, so reservation stations are cleared too.
- Duplicate nonzero tags from two requesters: legal for the arbiter, which treats them independently.

Decomposition:
- Shared package cdb_pkg holds:
  - Tag constants NOTAG=0, ADD_1..ADD_3=1..3, MULT_1..2=4..5, LD_1..3=6..8, ST_1..2=9..10.
  - Requester index constants REQ_ADD=0, REQ_MULT=1, REQ_LD=2, REQ_ST=3.
  - TAG_W, ROB_W, DATA_W.
- One sub-module, rr_pick: a combinational NREQ-wide rotate-priority picker. Inputs elig and ptr; output is a one-hot grant.
- The top level holds rr_ptr, the output registers, the field mux and bad_req.

Test Plan:
- Reset then idle: rst pulse with req=0 -> all outputs 0, grant=0; after release, cdb_id stays 0 for 5 cycles.
- Single request: req=0001, tag0=1, data0=0x55, rob0=2 -> grant=0001 in the same cycle; next cycle cdb_valid=1, cdb_id=1, cdb_data=0x55, cdb_rob=2; then req dropped -> bus idle.
- Round-robin:
  - Stimulus: req=1111 held, tags 1/4/6/9 on requesters 0..3, starting from rr_ptr=0.
  - Response: grants in order 0,1,2,3,0.
  - Bus cdb_id sequence one cycle later: 1,4,6,9,1.
- Stall: req=0110 with cdb_stall=1 for 3 cycles -> grant=0 and bus idle for 3 cycles; stall released -> grant=0010 first, then 0100.
- Tag-zero request: req=1000 with tag3=0 -> grant=0 and bus idle; bad_req=1 exactly one cycle later. A concurrent req0 with tag 2 is still granted.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while cdb_valid=1, cdb_id=5.
  - Response: outputs go to 0 before the next clk edge; after release, rr_ptr=0, so with req=1010 held, requester 1 is granted first.
